// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, aligner states and the
// symbol decode / token classification helpers.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] c;
  } ctrl_t;

  // Undo the transition-minimising stage: bit 9 = inversion, bit 8 = XOR (1) / XNOR (0).
  function automatic logic [7:0] tmds_decode_word(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] d;
    t    = q[9] ? ~q[7:0] : q[7:0];
    d    = '0;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    return d;
  endfunction

  function automatic ctrl_t tmds_is_ctrl(input logic [9:0] q);
    ctrl_t r;
    r.hit = 1'b1;
    r.c   = 2'b00;
    case (q)
      TOK_C00: r.c = 2'b00;
      TOK_C01: r.c = 2'b01;
      TOK_C10: r.c = 2'b10;
      TOK_C11: r.c = 2'b11;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Two-word window plus bit-slip select; the FSM slips the offset until a run
// of control tokens lines up, then holds it until tokens disappear.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int SEARCH_WAIT = 16,
  parameter int CTRL_RUN    = 8,
  parameter int LOSS_LIMIT  = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_word,
  output logic [9:0] o_symbol,
  output state_e     o_state,
  output logic [3:0] o_offset
);

  localparam int MISS_W = (SEARCH_WAIT > 1) ? $clog2(SEARCH_WAIT) : 1;
  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int LOSS_W = (LOSS_LIMIT > 1) ? $clog2(LOSS_LIMIT) : 1;

  logic [9:0]        w_cur_q, w_prev_q;
  state_e            state_q, state_d;
  logic [3:0]        offset_q, offset_d, offset_next;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [18:0]       win;
  logic [9:0]        cand [10];
  ctrl_t             ctrl;

  // w_cur[9] never reaches a 10-bit slice at offsets 0..9, so it is left out.
  assign win = {w_cur_q[8:0], w_prev_q};

  for (genvar gi = 0; gi < 10; gi++) begin : g_slice
    assign cand[gi] = win[gi+9:gi];
  end

  assign o_symbol    = cand[offset_q];
  assign ctrl        = tmds_is_ctrl(o_symbol);
  assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  assign o_state     = state_q;
  assign o_offset    = offset_q;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    miss_d   = miss_q;
    run_d    = run_q;
    loss_d   = loss_q;
    case (state_q)
      SEARCH: begin
        if (ctrl.hit) begin
          state_d = VERIFY;
          run_d   = RUN_W'(1);
        end else if (miss_q >= MISS_W'(SEARCH_WAIT - 1)) begin
          offset_d = offset_next;
          miss_d   = '0;
        end else begin
          miss_d = miss_q + 1'b1;
        end
      end
      VERIFY: begin
        // A broken run keeps the offset and the accumulated miss count.
        if (ctrl.hit) begin
          if (run_q >= RUN_W'(CTRL_RUN - 1)) begin
            state_d = LOCKED;
            run_d   = RUN_W'(CTRL_RUN);
            loss_d  = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (ctrl.hit) begin
          loss_d = '0;
        end else if (loss_q >= LOSS_W'(LOSS_LIMIT - 1)) begin
          state_d  = SEARCH;
          offset_d = offset_next;
          miss_d   = '0;
        end else begin
          loss_d = loss_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cur_q  <= '0;
      w_prev_q <= '0;
      state_q  <= SEARCH;
      offset_q <= '0;
      miss_q   <= '0;
      run_q    <= '0;
      loss_q   <= '0;
    end else begin
      w_cur_q  <= i_word;
      w_prev_q <= w_cur_q;
      state_q  <= state_d;
      offset_q <= offset_d;
      miss_q   <= miss_d;
      run_q    <= run_d;
      loss_q   <= loss_d;
    end
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// One TMDS receive channel: aligner followed by the registered decode stage.
// Optional disparity-rule error counter is enabled with TMDS_RX_ERRCHK_EN.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_WAIT = 16,
  parameter int CTRL_RUN    = 8,
  parameter int LOSS_LIMIT  = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  i_word,
`ifdef TMDS_RX_ERRCHK_EN
  input  logic        i_err_clr,
  output logic        o_err,
  output logic [15:0] o_err_cnt,
`endif
  output logic [7:0]  o_data,
  output logic [1:0]  o_c,
  output logic        o_de,
  output logic        o_locked,
  output logic [3:0]  o_offset
);

  logic [9:0] symbol;
  state_e     state;
  ctrl_t      ctrl;
  logic [7:0] dec;
  logic [7:0] data_q, data_d;
  logic [1:0] c_q, c_d;
  logic       de_q, de_d;

  tmds_word_aligner #(
    .SEARCH_WAIT(SEARCH_WAIT),
    .CTRL_RUN   (CTRL_RUN),
    .LOSS_LIMIT (LOSS_LIMIT)
  ) u_aligner (
    .clk     (clk),
    .rst     (rst),
    .i_word  (i_word),
    .o_symbol(symbol),
    .o_state (state),
    .o_offset(o_offset)
  );

  assign ctrl = tmds_is_ctrl(symbol);
  assign dec  = tmds_decode_word(symbol);

  // Gate on the state that saw this symbol, not the one it produces.
  always_comb begin
    data_d = '0;
    c_d    = '0;
    de_d   = 1'b0;
    if (state == LOCKED) begin
      if (ctrl.hit) begin
        c_d = ctrl.c;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
        c_d    = c_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      c_q    <= '0;
      de_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      c_q    <= c_d;
      de_q   <= de_d;
    end
  end

  assign o_data   = data_q;
  assign o_c      = c_q;
  assign o_de     = de_q;
  assign o_locked = (state == LOCKED);

`ifdef TMDS_RX_ERRCHK_EN
  logic [3:0]  ones;
  logic        xnor_exp;
  logic        err_d, err_q;
  logic [15:0] err_cnt_q, err_cnt_d;

  // The encoder picks XNOR for ones-heavy bytes; a flag matching that choice is wrong.
  assign ones     = 4'($countones(dec));
  assign xnor_exp = (ones > 4'd4) || ((ones == 4'd4) && !dec[0]);
  assign err_d    = (state == LOCKED) && !ctrl.hit && (symbol[8] == xnor_exp);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_err_clr) begin
      err_cnt_d = {15'd0, err_d};
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
`endif

endmodule
